// File: rtl/k12_alu_trace.sv
// ALU response collector: captures every change of the {a, b, inst, res, cond} bus
// into a small FIFO and serializes each record as 6 bytes over a valid/ready stream.
module k12_alu_trace #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [15:0] inst,
    input  logic [7:0]  res,
    input  logic        cond,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TUPLE_W = 41;
    localparam int ENTRY_W = TUPLE_W + 1;
    localparam int REC_BYTES = 6;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [2:0]       LAST_IDX   = 3'(REC_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [2:0]           idx_reg;
    logic [2:0]           idx_next;
    logic [ENTRY_W-1:0]   cur_reg;
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [PTR_W:0]       count_reg;
    logic                 first_flag_reg;
    logic                 drop_pending_reg;
    logic [TUPLE_W-1:0]   last_tuple_reg;
    logic [7:0]           drop_cnt_reg;

    logic [TUPLE_W-1:0]   tuple;
    logic                 capture;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 handshake;
    logic                 pop;
    logic                 push;
    logic                 drop;

    logic [8*REC_BYTES-1:0] rec_packed;
    logic [7:0]             rec_bytes [REC_BYTES];

    assign tuple      = {a, b, inst, res, cond};
    assign capture    = en && (first_flag_reg || (tuple != last_tuple_reg));
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_COUNT);
    assign out_valid  = (state_reg == SEND);
    assign handshake  = out_valid && out_ready;

    // A full FIFO can still accept a record when the serializer pops on the same edge.
    assign push = capture && (!fifo_full || pop);
    assign drop = capture && !push;

    // Serializer: IDLE pops as soon as data exists; SEND walks bytes 0..5 per handshake.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SEND;
                    idx_next   = '0;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next = '0;
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Record storage with a registered read into the serializer's holding register.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_reg] <= {drop_pending_reg, tuple};
        end
        if (rst_n && pop) begin
            cur_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            first_flag_reg   <= 1'b1;
            drop_pending_reg <= 1'b0;
            last_tuple_reg   <= '0;
            drop_cnt_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + COUNT_ONE;
                2'b01:   count_reg <= count_reg - COUNT_ONE;
                default: count_reg <= count_reg;
            endcase
            // last_tuple follows every capture, even one that is dropped.
            if (capture) begin
                last_tuple_reg <= tuple;
                first_flag_reg <= 1'b0;
            end
            if (push) begin
                drop_pending_reg <= 1'b0;
            end else if (drop) begin
                drop_pending_reg <= 1'b1;
            end
            if (drop && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    // cur_reg layout: {drop, a, b, inst, res, cond}; bytes go out B0 first.
    assign rec_packed = {1'b1, cur_reg[ENTRY_W-1], 5'b0, cur_reg[0], cur_reg[TUPLE_W-1:1]};

    generate
        for (genvar gi = 0; gi < REC_BYTES; gi++) begin : g_rec_byte
            assign rec_bytes[gi] = rec_packed[8*REC_BYTES-1-8*gi -: 8];
        end
    endgenerate

    assign out_data = out_valid ? rec_bytes[idx_reg] : 8'h00;
    assign drop_cnt = drop_cnt_reg;
    assign busy     = !fifo_empty || (state_reg == SEND);

endmodule

// File: tb/tb_k12_alu_trace.sv
// Bench for k12_alu_trace: directed scenarios plus random traffic, all checked
// against a queue-based record model evaluated once per clock edge.
module tb_k12_alu_trace;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] inst;
    logic [7:0]  res;
    logic        cond;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  drop_cnt;
    logic        busy;

    always #5 clk = ~clk;

    k12_alu_trace #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .a         (a),
        .b         (b),
        .inst      (inst),
        .res       (res),
        .cond      (cond),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending records, bytes of the record on the wire, drop bookkeeping.
    logic [41:0] m_fifo[$];
    logic [7:0]  m_bytes[$];
    bit          m_first = 1'b1;
    logic [40:0] m_last = '0;
    bit          m_dpend = 1'b0;
    int          m_dcnt = 0;
    int          rec_num = 0;

    logic [7:0]  dut_bytes[$];

    function automatic void model_edge(input bit r_n, input bit e, input logic [40:0] t, input bit rdy);
        bit          do_pop;
        int          pre_size;
        logic [41:0] ent;
        logic [7:0]  fa, fb, fres;
        logic [15:0] finst;
        if (!r_n) begin
            m_fifo.delete();
            m_bytes.delete();
            m_first = 1'b1;
            m_last  = '0;
            m_dpend = 1'b0;
            m_dcnt  = 0;
            return;
        end
        pre_size = m_fifo.size();
        if (m_bytes.size() != 0 && rdy) begin
            void'(m_bytes.pop_front());
            if (m_bytes.size() == 0) begin
                rec_num++;
                $display("record %0d sent", rec_num);
            end
        end
        do_pop = (m_bytes.size() == 0) && (pre_size != 0);
        if (do_pop) begin
            ent = m_fifo.pop_front();
            {fa, fb, finst, fres} = ent[40:1];
            m_bytes.push_back({1'b1, ent[41], 5'b00000, ent[0]});
            m_bytes.push_back(fa);
            m_bytes.push_back(fb);
            m_bytes.push_back(finst[15:8]);
            m_bytes.push_back(finst[7:0]);
            m_bytes.push_back(fres);
        end
        if (e && (m_first || t != m_last)) begin
            m_first = 1'b0;
            m_last  = t;
            if (pre_size < DEPTH || do_pop) begin
                m_fifo.push_back({m_dpend, t});
                m_dpend = 1'b0;
            end else begin
                m_dpend = 1'b1;
                if (m_dcnt < 255) m_dcnt++;
            end
        end
    endfunction

    task automatic cycle();
        bit          r_n;
        bit          e;
        bit          rdy;
        logic [40:0] t;
        r_n = rst_n;
        e   = en;
        rdy = out_ready;
        t   = {a, b, inst, res, cond};
        if (rst_n && out_valid && out_ready) dut_bytes.push_back(out_data);
        @(posedge clk);
        model_edge(r_n, e, t, rdy);
        #1;
        check_val("out_valid", out_valid, m_bytes.size() != 0);
        if (m_bytes.size() != 0) check_val("out_data", out_data, m_bytes[0]);
        check_val("busy", busy, (m_fifo.size() != 0) || (m_bytes.size() != 0));
        check_val("drop_cnt", drop_cnt, m_dcnt);
    endtask

    task automatic set_tuple(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] vi,
                             input logic [7:0] vr, input logic vc);
        a = va; b = vb; inst = vi; res = vr; cond = vc;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && dut_bytes.size() < n; i++) cycle();
        if (dut_bytes.size() < n) check_val("wait_bytes_timeout", dut_bytes.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            cycle();
            if (!busy) break;
        end
        if (busy) check_val("wait_idle_timeout", busy, 0);
    endtask

    logic [7:0]  exp1 [6];
    logic [40:0] pool [4];
    logic [63:0] rnd;

    initial begin
        rst_n = 1'b0; en = 1'b0; out_ready = 1'b1;
        set_tuple(8'h00, 8'h00, 16'h0000, 8'h00, 1'b0);

        // Reset, then a single capture
        for (int i = 0; i < 3; i++) cycle();
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_drop_cnt", drop_cnt, 0);
        check_val("rst_busy", busy, 0);
        dut_bytes.delete();
        rst_n = 1'b1; en = 1'b1;
        set_tuple(8'h12, 8'h34, 16'h0A5F, 8'h46, 1'b1);
        cycle();
        check_val("lat_capture_edge", out_valid, 0);
        cycle();
        check_val("lat_next_edge", out_valid, 1);
        check_val("lat_b0", out_data, 8'h81);
        wait_idle(30);
        for (int i = 0; i < 10; i++) cycle();
        exp1 = '{8'h81, 8'h12, 8'h34, 8'h0A, 8'h5F, 8'h46};
        check_val("single_len", dut_bytes.size(), 6);
        for (int i = 0; i < 6 && i < dut_bytes.size(); i++) check_val("single_byte", dut_bytes[i], exp1[i]);

        // No-change suppression and en gating
        dut_bytes.delete();
        res = 8'h00; cycle();
        res = 8'h01; cycle();
        wait_idle(40);
        for (int i = 0; i < 10; i++) cycle();
        check_val("suppress_len", dut_bytes.size(), 12);
        if (dut_bytes.size() >= 12) begin
            check_val("suppress_res0", dut_bytes[5], 8'h00);
            check_val("suppress_res1", dut_bytes[11], 8'h01);
        end
        en = 1'b0; a = 8'h99;
        for (int i = 0; i < 10; i++) cycle();
        check_val("en_gate_len", dut_bytes.size(), 12);
        en = 1'b1;
        wait_idle(30);
        check_val("en_raise_len", dut_bytes.size(), 18);
        if (dut_bytes.size() >= 18) check_val("en_raise_a", dut_bytes[13], 8'h99);

        // Backpressure
        dut_bytes.delete();
        out_ready = 1'b0;
        set_tuple(8'h20, 8'h21, 16'h2223, 8'h24, 1'b1);
        for (int i = 0; i < 10 && !out_valid; i++) cycle();
        check_val("bp_valid_rise", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_val("bp_hold_data", out_data, 8'h81);
            check_val("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        wait_idle(30);
        exp1 = '{8'h81, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        check_val("bp_len", dut_bytes.size(), 6);
        for (int i = 0; i < 6 && i < dut_bytes.size(); i++) check_val("bp_byte", dut_bytes[i], exp1[i]);

        // Overflow and drop flag
        dut_bytes.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_tuple(8'h40 + 8'(i), 8'h11, 16'h0100 + 16'(i), 8'h55, 1'b0);
            cycle();
        end
        check_val("ovf_drop_cnt", drop_cnt, 2);
        out_ready = 1'b1;
        wait_bytes(6, 50);
        set_tuple(8'h50, 8'h11, 16'h0200, 8'h55, 1'b0);
        wait_idle(100);
        check_val("ovf_len", dut_bytes.size(), 36);
        for (int k = 0; k < 6 && 6 * k < dut_bytes.size(); k++)
            check_val("ovf_drop_bit", dut_bytes[6 * k][6], (k == 5) ? 1 : 0);
        if (dut_bytes.size() >= 36) begin
            check_val("ovf_rec4_a", dut_bytes[25], 8'h44);
            check_val("ovf_rec5_a", dut_bytes[31], 8'h50);
        end

        // Full FIFO with push and pop on the same edge
        dut_bytes.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_tuple(8'h60 + 8'(i), 8'h22, 16'h0300 + 16'(i), 8'h66, 1'b1);
            cycle();
        end
        check_val("pp_fill_drop_cnt", drop_cnt, 2);
        out_ready = 1'b1;
        wait_bytes(5, 20);
        set_tuple(8'h70, 8'h22, 16'h0400, 8'h66, 1'b1);
        cycle();
        check_val("pp_drop_cnt", drop_cnt, 2);
        check_val("pp_busy", busy, 1);
        wait_idle(60);
        check_val("pp_len", dut_bytes.size(), 36);
        for (int k = 0; k < 6 && 6 * k < dut_bytes.size(); k++)
            check_val("pp_drop_bit", dut_bytes[6 * k][6], 0);
        if (dut_bytes.size() >= 36) check_val("pp_last_a", dut_bytes[31], 8'h70);

        // Reset mid-record
        dut_bytes.delete();
        set_tuple(8'h33, 8'h44, 16'h5566, 8'h77, 1'b1);
        wait_bytes(3, 20);
        rst_n = 1'b0;
        cycle();
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        dut_bytes.delete();
        wait_idle(30);
        check_val("post_rst_len", dut_bytes.size(), 6);
        if (dut_bytes.size() >= 6) begin
            check_val("post_rst_b0", dut_bytes[0], 8'h81);
            check_val("post_rst_a", dut_bytes[1], 8'h33);
        end

        // Random traffic against the model
        for (int k = 0; k < 4; k++) begin
            rnd = {$urandom(), $urandom()};
            pool[k] = rnd[40:0];
        end
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) {a, b, inst, res, cond} = pool[$urandom_range(0, 3)];
            if (((i / 300) % 2) == 1) out_ready = ($urandom_range(0, 3) == 0);
            else out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
